sha256_msg_padder: RTL and testbench



---
 rtl/sha256_msg_padder.sv | 251 +++++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Front end for sha256_core. Packs a byte-granular stream of 32-bit big-endian
// words into 512-bit blocks. Applies SHA-2 padding: a 0x80 byte, zero fill,
// then the 64-bit message bit length. Drives the core's init/next handshake and
// registers the final digest.
// Optional build macro: SHA256_MSG_PADDER_ABORT_EN adds an 'abort' input that
// discards the message in progress.
`timescale 1ns/1ps
module sha256_msg_padder #(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mode,
`ifdef SHA256_MSG_PADDER_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         core_init,
    output logic         core_next,
    output logic         core_mode,
    output logic [511:0] core_block,
    input  logic         core_ready,
    input  logic [255:0] core_digest,
    input  logic         core_digest_valid,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [2:0] ST_FILL  = 3'd0;
    localparam logic [2:0] ST_PAD   = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_EXTRA = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;

    logic [2:0]       state_reg;
    logic [LEN_W-1:0] count_reg;
    logic [3:0]       word_idx_reg;
    logic             first_blk_reg;
    logic             final_reg;
    logic             need_extra_reg;
    logic             pad_placed_reg;
    logic             abort_flag_reg;
    logic             mode_reg;
    logic             in_ready_reg;
    logic             digest_valid_reg;
    logic [511:0]     block_reg;
    logic [255:0]     digest_reg;

    logic             accept;
    logic             abort_req;
    logic [31:0]      word_masked;
    logic [2:0]       byte_add;
    logic [5:0]       pad_pos;
    logic [63:0]      bit_len;
    logic [511:0]     pad_block;
    logic [511:0]     extra_block;

`ifdef SHA256_MSG_PADDER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign accept   = in_valid & in_ready_reg;
    // Byte counts above 4 are treated as a full word.
    assign byte_add = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign pad_pos  = count_reg[5:0];
    assign bit_len  = 64'(count_reg) << 3;

    // Keep only the valid upper bytes of the incoming word.
    always_comb begin
        word_masked = in_data;
        case (in_bytes)
            3'd0:    word_masked = 32'h0;
            3'd1:    word_masked = {in_data[31:24], 24'h0};
            3'd2:    word_masked = {in_data[31:16], 16'h0};
            3'd3:    word_masked = {in_data[31:8], 8'h0};
            default: word_masked = in_data;
        endcase
    end

    // Padded view of the buffer. Bytes before the pad position are kept.
    // The pad byte itself becomes 0x80, and everything after it is zeroed.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_pad
            localparam logic [5:0] BYTE_IDX = 6'(gi);
            assign pad_block[8*(63-gi) +: 8] =
                (BYTE_IDX == pad_pos) ? 8'h80 :
                (BYTE_IDX >  pad_pos) ? 8'h00 :
                                        block_reg[8*(63-gi) +: 8];
        end
    endgenerate

    // Trailing block, used when the length did not fit after the data.
    assign extra_block = {(pad_placed_reg ? 8'h00 : 8'h80), 440'h0, bit_len};

    // Control FSM together with the block buffer and the output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_FILL;
            count_reg        <= '0;
            word_idx_reg     <= 4'd0;
            first_blk_reg    <= 1'b1;
            final_reg        <= 1'b0;
            need_extra_reg   <= 1'b0;
            pad_placed_reg   <= 1'b0;
            abort_flag_reg   <= 1'b0;
            mode_reg         <= 1'b0;
            in_ready_reg     <= 1'b0;
            digest_valid_reg <= 1'b0;
            block_reg        <= '0;
            digest_reg       <= '0;
        end else begin
            in_ready_reg     <= 1'b0;
            digest_valid_reg <= 1'b0;
            case (state_reg)
                ST_FILL: begin
                    in_ready_reg <= 1'b1;
                    if (abort_req) begin
                        block_reg      <= '0;
                        count_reg      <= '0;
                        word_idx_reg   <= 4'd0;
                        first_blk_reg  <= 1'b1;
                        final_reg      <= 1'b0;
                        need_extra_reg <= 1'b0;
                        pad_placed_reg <= 1'b0;
                        abort_flag_reg <= 1'b0;
                    end else if (accept) begin
                        // {~idx, 5'h1f} is the MSB of word idx, counting from bit 511 down.
                        block_reg[{~word_idx_reg, 5'h1f} -: 32] <= word_masked;
                        count_reg    <= count_reg + LEN_W'(byte_add);
                        word_idx_reg <= word_idx_reg + 4'd1;
                        if (first_blk_reg && (word_idx_reg == 4'd0)) begin
                            mode_reg <= mode;
                        end
                        if (in_last) begin
                            state_reg    <= ST_PAD;
                            in_ready_reg <= 1'b0;
                        end else if (word_idx_reg == 4'd15) begin
                            final_reg    <= 1'b0;
                            state_reg    <= ST_ISSUE;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (abort_req) begin
                        block_reg      <= '0;
                        count_reg      <= '0;
                        word_idx_reg   <= 4'd0;
                        first_blk_reg  <= 1'b1;
                        final_reg      <= 1'b0;
                        need_extra_reg <= 1'b0;
                        pad_placed_reg <= 1'b0;
                        abort_flag_reg <= 1'b0;
                        state_reg      <= ST_FILL;
                        in_ready_reg   <= 1'b1;
                    end else begin
                        // A wrapped word index with p=0 means the data exactly filled the block.
                        if ((pad_pos == 6'd0) && (word_idx_reg == 4'd0)) begin
                            need_extra_reg <= 1'b1;
                            pad_placed_reg <= 1'b0;
                        end else if (pad_pos <= 6'd55) begin
                            block_reg <= {pad_block[511:64], bit_len};
                            final_reg <= 1'b1;
                        end else begin
                            block_reg      <= pad_block;
                            need_extra_reg <= 1'b1;
                            pad_placed_reg <= 1'b1;
                        end
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort_req) begin
                        abort_flag_reg <= 1'b1;
                    end
                    first_blk_reg <= 1'b0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (abort_req) begin
                        abort_flag_reg <= 1'b1;
                    end
                    if (core_ready && core_digest_valid) begin
                        if (abort_flag_reg || abort_req) begin
                            block_reg      <= '0;
                            count_reg      <= '0;
                            word_idx_reg   <= 4'd0;
                            first_blk_reg  <= 1'b1;
                            final_reg      <= 1'b0;
                            need_extra_reg <= 1'b0;
                            pad_placed_reg <= 1'b0;
                            abort_flag_reg <= 1'b0;
                            state_reg      <= ST_FILL;
                            in_ready_reg   <= 1'b1;
                        end else if (final_reg) begin
                            state_reg <= ST_OUT;
                        end else if (need_extra_reg) begin
                            state_reg <= ST_EXTRA;
                        end else begin
                            block_reg    <= '0;
                            word_idx_reg <= 4'd0;
                            state_reg    <= ST_FILL;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_EXTRA: begin
                    if (abort_req) begin
                        abort_flag_reg <= 1'b1;
                    end
                    block_reg      <= extra_block;
                    final_reg      <= 1'b1;
                    need_extra_reg <= 1'b0;
                    state_reg      <= ST_ISSUE;
                end
                ST_OUT: begin
                    digest_reg       <= core_digest;
                    digest_valid_reg <= 1'b1;
                    count_reg        <= '0;
                    word_idx_reg     <= 4'd0;
                    final_reg        <= 1'b0;
                    pad_placed_reg   <= 1'b0;
                    first_blk_reg    <= 1'b1;
                    state_reg        <= ST_FILL;
                    in_ready_reg     <= 1'b1;
                end
                default: begin
                    state_reg <= ST_FILL;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign core_init    = (state_reg == ST_ISSUE) &&  first_blk_reg;
    assign core_next    = (state_reg == ST_ISSUE) && !first_blk_reg;
    assign core_mode    = mode_reg;
    assign core_block   = block_reg;
    assign digest       = digest_reg;
    assign digest_valid = digest_valid_reg;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder
// Directed bench for sha256_msg_padder. A behavioural SHA-256 core answers
// init/next pulses. Expected blocks and digests are queued when a message is
// issued. A monitor pops and compares them whenever the padder presents a block
// or a digest.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

    logic         clk;
    logic         reset_n;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         core_init;
    logic         core_next;
    logic         core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic         core_digest_valid;
    logic [255:0] digest;
    logic         digest_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         init;
        logic [511:0] blk;
    } blk_exp_t;

    typedef struct packed {
        logic         is224;
        logic [255:0] d;
    } dig_exp_t;

    blk_exp_t exp_blk_q[$];
    dig_exp_t exp_dig_q[$];

    logic [7:0] msg_bytes [64];
    int         msg_len;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224 =
        256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    // Hand-computed padded blocks
    localparam logic [447:0] M56 =
        448'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'd24};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 416'h0, 64'd0};
    localparam logic [511:0] BLK_56A   = {M56, 32'h80000000, 32'h0};
    localparam logic [511:0] BLK_56B   = {448'h0, 64'd448};
    localparam logic [511:0] BLK_Z1    = 512'h0;
    localparam logic [511:0] BLK_Z2    = {8'h80, 440'h0, 64'd512};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_224   = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

    sha256_msg_padder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .mode              (mode),
`ifdef SHA256_MSG_PADDER_ABORT_EN
        .abort             (1'b0),
`endif
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_bytes          (in_bytes),
        .core_init         (core_init),
        .core_next         (core_next),
        .core_mode         (core_mode),
        .core_block        (core_block),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .digest            (digest),
        .digest_valid      (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression function
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Behavioural core, sampled on the falling edge.
    // It is busy for a few cycles after each init/next pulse.
    logic [255:0] h_st;
    int           busy;
    initial begin
        core_ready        = 1'b1;
        core_digest_valid = 1'b0;
        core_digest       = '0;
        h_st              = '0;
        busy              = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                core_ready        = 1'b1;
                core_digest_valid = 1'b0;
                busy              = 0;
            end else if (core_init || core_next) begin
                if (core_init) h_st = core_mode ? IV256 : IV224;
                h_st              = sha_compress(h_st, core_block);
                core_ready        = 1'b0;
                core_digest_valid = 1'b0;
                busy              = 5;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    core_ready        = 1'b1;
                    core_digest_valid = 1'b1;
                    core_digest       = h_st;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        blk_exp_t eb;
        dig_exp_t ed;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (core_init || core_next) begin
                    if (exp_blk_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_block: init=%0b next=%0b, required no block", core_init, core_next);
                    end else begin
                        eb = exp_blk_q.pop_front();
                        $display("block: init=%0b next=%0b data=%0h", core_init, core_next, core_block);
                        chk("blk_kind", 512'({core_init, core_next}), 512'({eb.init, ~eb.init}));
                        chk("blk_data", core_block, eb.blk);
                    end
                end
                if (digest_valid) begin
                    if (exp_dig_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_digest: got %0h, required no digest", digest);
                    end else begin
                        ed = exp_dig_q.pop_front();
                        $display("digest: %0h", digest);
                        if (ed.is224) chk("digest224", 512'(digest[255:32]), 512'(ed.d[255:32]));
                        else          chk("digest256", 512'(digest), 512'(ed.d));
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        $display("reset check: %s", tag);
        chk({tag, "_in_ready"},     512'(in_ready),     512'(0));
        chk({tag, "_core_init"},    512'(core_init),    512'(0));
        chk({tag, "_core_next"},    512'(core_next),    512'(0));
        chk({tag, "_core_mode"},    512'(core_mode),    512'(0));
        chk({tag, "_core_block"},   core_block,         512'(0));
        chk({tag, "_digest"},       512'(digest),       512'(0));
        chk({tag, "_digest_valid"}, 512'(digest_valid), 512'(0));
    endtask

    // Present one word and hold it until it is accepted (bounded)
    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_bytes = nb;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            total++; bad++;
            $display("FAIL ready_timeout: in_ready=0 after 500 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send msg_bytes[0..msg_len-1]; unused lanes carry junk that must be masked
    task automatic send_msg(input int gap);
        int nw;
        int nb;
        logic [31:0] wd;
        nw = (msg_len == 0) ? 1 : (msg_len + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            wd = 32'hEEEEEEEE;
            nb = msg_len - 4*wi;
            if (nb > 4) nb = 4;
            for (int k = 0; k < nb; k++) wd[31 - 8*k -: 8] = msg_bytes[4*wi + k];
            send_word(wd, 3'(nb), wi == nw - 1);
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_blk_q.size() != 0 || exp_dig_q.size() != 0) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d blocks and %0d digests pending, required 0",
                     exp_blk_q.size(), exp_dig_q.size());
            exp_blk_q.delete();
            exp_dig_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic push_blk(input logic init, input logic [511:0] blk);
        exp_blk_q.push_back('{init: init, blk: blk});
    endtask

    task automatic push_dig(input logic is224, input logic [255:0] d);
        exp_dig_q.push_back('{is224: is224, d: d});
    endtask

    task automatic load_abc();
        msg_len = 3;
        msg_bytes[0] = 8'h61; msg_bytes[1] = 8'h62; msg_bytes[2] = 8'h63;
    endtask

    initial begin
        logic [447:0] m56;
        logic [255:0] d_zero;
        int guard;
        in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
        mode = 1'b1; reset_n = 1'b0; msg_len = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset_n = 1'b1;
        chk("ready_at_release", 512'(in_ready), 512'(0));
        @(posedge clk); #1;
        chk("ready_after_release", 512'(in_ready), 512'(1));

        // "abc", SHA-256
        $display("msg: abc sha256");
        load_abc(); mode = 1'b1;
        push_blk(1'b1, BLK_ABC); push_dig(1'b0, D_ABC);
        send_msg(0); wait_drain();

        // Empty message
        $display("msg: empty sha256");
        msg_len = 0;
        push_blk(1'b1, BLK_EMPTY); push_dig(1'b0, D_EMPTY);
        send_msg(0); wait_drain();

        // 56 bytes: length does not fit, so the 0x80 byte is placed and an extra block follows
        $display("msg: 56 bytes sha256");
        m56 = M56;
        msg_len = 56;
        for (int i = 0; i < 56; i++) msg_bytes[i] = m56[447 - 8*i -: 8];
        push_blk(1'b1, BLK_56A); push_blk(1'b0, BLK_56B); push_dig(1'b0, D_56);
        send_msg(0); wait_drain();

        // "abc", SHA-224
        $display("msg: abc sha224");
        load_abc(); mode = 1'b0;
        push_blk(1'b1, BLK_ABC); push_dig(1'b1, D_224);
        send_msg(0); wait_drain();

        // 64 zero bytes: last word fills the block exactly
        $display("msg: 64 zero bytes sha256");
        mode = 1'b1;
        msg_len = 64;
        for (int i = 0; i < 64; i++) msg_bytes[i] = 8'h00;
        d_zero = sha_compress(sha_compress(IV256, BLK_Z1), BLK_Z2);
        push_blk(1'b1, BLK_Z1); push_blk(1'b0, BLK_Z2); push_dig(1'b0, d_zero);
        send_msg(0); wait_drain();

        // "abc" with idle gaps, reset asserted while the core is busy
        $display("msg: abc with gaps, reset during wait");
        load_abc();
        repeat (2) @(posedge clk);
        #1;
        push_blk(1'b1, BLK_ABC);
        send_msg(3);
        guard = 0;
        while (exp_blk_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL issue_timeout: block still pending, required issued");
            exp_blk_q.delete();
        end
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_wait");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // The next message after reset must hash correctly
        $display("msg: abc after reset");
        load_abc();
        push_blk(1'b1, BLK_ABC); push_dig(1'b0, D_ABC);
        send_msg(1); wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2ms, required finished");
        $fatal(1, "watchdog");
    end

endmodule
